traffic_sequencer: RTL and testbench

//  Central traffic-light controller behind the Labkit top level. Sequences the main/side lights and the

---
 rtl/traffic_pkg.sv | 44 ++++
 rtl/interval_timer.sv | 35 +++
 rtl/traffic_sequencer.sv | 108 ++++++++++
 tb/tb_traffic_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - state codes, selector codes and LED patterns for the traffic sequencer
package traffic_pkg;

  // State codes; 3'd7 is unused and recovers to ST_MAIN_G1
  localparam logic [2:0] ST_MAIN_G1 = 3'd0;
  localparam logic [2:0] ST_MAIN_G2 = 3'd1;
  localparam logic [2:0] ST_MAIN_Y  = 3'd2;
  localparam logic [2:0] ST_WALK    = 3'd3;
  localparam logic [2:0] ST_SIDE_G  = 3'd4;
  localparam logic [2:0] ST_SIDE_GX = 3'd5;
  localparam logic [2:0] ST_SIDE_Y  = 3'd6;

  // Time_Parameter_Selector codes; 2'b11 writes nothing
  localparam logic [1:0] SEL_BASE = 2'b00;
  localparam logic [1:0] SEL_EXT  = 2'b01;
  localparam logic [1:0] SEL_YEL  = 2'b10;

  // Bit positions inside LEDs = {mainR,mainY,mainG,sideR,sideY,sideG,walk}
  localparam int LED_MAIN_R = 6;
  localparam int LED_MAIN_Y = 5;
  localparam int LED_MAIN_G = 4;
  localparam int LED_SIDE_R = 3;
  localparam int LED_SIDE_Y = 2;
  localparam int LED_SIDE_G = 1;
  localparam int LED_WALK   = 0;

  localparam logic [6:0] LEDS_MAIN_G = 7'((1 << LED_MAIN_G) | (1 << LED_SIDE_R));
  localparam logic [6:0] LEDS_MAIN_Y = 7'((1 << LED_MAIN_Y) | (1 << LED_SIDE_R));
  localparam logic [6:0] LEDS_WALK   = 7'((1 << LED_MAIN_R) | (1 << LED_SIDE_R) | (1 << LED_WALK));
  localparam logic [6:0] LEDS_SIDE_G = 7'((1 << LED_MAIN_R) | (1 << LED_SIDE_G));
  localparam logic [6:0] LEDS_SIDE_Y = 7'((1 << LED_MAIN_R) | (1 << LED_SIDE_Y));

  function automatic logic [6:0] leds_for_state(input logic [2:0] st);
    case (st)
      ST_MAIN_G1, ST_MAIN_G2: leds_for_state = LEDS_MAIN_G;
      ST_MAIN_Y:              leds_for_state = LEDS_MAIN_Y;
      ST_WALK:                leds_for_state = LEDS_WALK;
      ST_SIDE_G, ST_SIDE_GX:  leds_for_state = LEDS_SIDE_G;
      ST_SIDE_Y:              leds_for_state = LEDS_SIDE_Y;
      default:                leds_for_state = LEDS_MAIN_G;
    endcase
  endfunction

endpackage

// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - phase interval timer counting enable ticks from a start pulse
module interval_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          tick,
  input  logic [TW-1:0] interval,
  output logic          expired
);

  logic [TW-1:0] cnt;
  logic [TW-1:0] load_val;

  // A zero interval would never let the phase run; treat it as one tick
  always_comb begin
    load_val = (interval == '0) ? TW'(1) : interval;
  end

  // Load on start (a tick in the load cycle already counts), then count ticks down to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= load_val - TW'(tick);
    end else if (tick && cnt != '0) begin
      cnt <= cnt - TW'(1);
    end
  end

  // The count left over from the previous phase is stale during the start cycle
  assign expired = (cnt == '0) && !start;

endmodule

// File: rtl/traffic_sequencer.sv
// rtl/traffic_sequencer.sv - traffic-light FSM with reprogrammable base/extend/yellow intervals
module traffic_sequencer
  import traffic_pkg::*;
#(
  parameter int TW     = 4,
  parameter int T_BASE = 6,
  parameter int T_EXT  = 3,
  parameter int T_YEL  = 2
) (
  input  logic          clk,
  input  logic          Reset_n,
  input  logic          tick,
  input  logic          Sensor,
  input  logic          Walk_Request,
  input  logic          Reprogram,
  input  logic [1:0]    Time_Parameter_Selector,
  input  logic [TW-1:0] Time_Value,
  output logic [6:0]    LEDs
);

  logic [2:0]    state;
  logic [2:0]    state_next;
  logic          start_q;
  logic          expired;
  logic          walk_pend;
  logic [TW-1:0] p_base;
  logic [TW-1:0] p_ext;
  logic [TW-1:0] p_yel;
  logic [TW-1:0] interval;

  // Interval belonging to the current state; the timer only looks at it during start
  always_comb begin
    case (state)
      ST_MAIN_Y, ST_SIDE_Y: interval = p_yel;
      ST_WALK, ST_SIDE_GX:  interval = p_ext;
      default:              interval = p_base;
    endcase
  end

  interval_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst_n    (Reset_n),
    .start    (start_q),
    .tick     (tick),
    .interval (interval),
    .expired  (expired)
  );

  // Next-state selection; Reprogram overrides everything, Sensor is looked at only on expiry
  always_comb begin
    state_next = state;
    if (Reprogram) begin
      state_next = ST_MAIN_G1;
    end else begin
      case (state)
        ST_MAIN_G1: if (expired) state_next = Sensor ? ST_MAIN_Y : ST_MAIN_G2;
        ST_MAIN_G2: if (expired) state_next = ST_MAIN_Y;
        ST_MAIN_Y:  if (expired) state_next = walk_pend ? ST_WALK : ST_SIDE_G;
        ST_WALK:    if (expired) state_next = ST_SIDE_G;
        ST_SIDE_G:  if (expired) state_next = Sensor ? ST_SIDE_GX : ST_SIDE_Y;
        ST_SIDE_GX: if (expired) state_next = ST_SIDE_Y;
        ST_SIDE_Y:  if (expired) state_next = ST_MAIN_G1;
        default:    state_next = ST_MAIN_G1;
      endcase
    end
  end

  // State, LED register and the timer start pulse raised on every state entry or reprogram cycle
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= ST_MAIN_G1;
      start_q <= 1'b1;
      LEDs    <= LEDS_MAIN_G;
    end else begin
      state   <= state_next;
      start_q <= Reprogram || (state_next != state);
      LEDs    <= leds_for_state(state_next);
    end
  end

  // Pending pedestrian request; a new request beats the clear on WALK entry
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      walk_pend <= 1'b0;
    end else if (Walk_Request) begin
      walk_pend <= 1'b1;
    end else if (state_next == ST_WALK && state != ST_WALK) begin
      walk_pend <= 1'b0;
    end
  end

  // Parameter file written every cycle Reprogram is held
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      p_base <= TW'(T_BASE);
      p_ext  <= TW'(T_EXT);
      p_yel  <= TW'(T_YEL);
    end else if (Reprogram) begin
      case (Time_Parameter_Selector)
        SEL_BASE: p_base <= Time_Value;
        SEL_EXT:  p_ext  <= Time_Value;
        SEL_YEL:  p_yel  <= Time_Value;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_sequencer.sv
// tb/tb_traffic_sequencer.sv - vector table, corner sequences and random run against a phase model
module tb_traffic_sequencer;

  localparam logic [6:0] MG = 7'b0011000;
  localparam logic [6:0] MY = 7'b0101000;
  localparam logic [6:0] WK = 7'b1001001;
  localparam logic [6:0] SG = 7'b1000010;
  localparam logic [6:0] SY = 7'b1000100;

  logic       clk;
  logic       Reset_n;
  logic       tick;
  logic       Sensor;
  logic       Walk_Request;
  logic       Reprogram;
  logic [1:0] Time_Parameter_Selector;
  logic [3:0] Time_Value;
  logic [6:0] LEDs;

  int n_cmp = 0;
  int n_bad = 0;

  traffic_sequencer dut (
    .clk                     (clk),
    .Reset_n                 (Reset_n),
    .tick                    (tick),
    .Sensor                  (Sensor),
    .Walk_Request            (Walk_Request),
    .Reprogram               (Reprogram),
    .Time_Parameter_Selector (Time_Parameter_Selector),
    .Time_Value              (Time_Value),
    .LEDs                    (LEDs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Phase-level reference: which light phase we are in and how many ticks it has consumed
  typedef enum int {P_G1, P_G2, P_MY, P_WALK, P_SG, P_SGX, P_SY} phase_t;

  phase_t m_ph;
  int     m_seen;
  int     m_need;
  bit     m_first;
  bit     m_walk;
  int     m_base, m_ext, m_yel;

  function automatic logic [6:0] phase_led(input phase_t p);
    case (p)
      P_G1, P_G2:  return MG;
      P_MY:        return MY;
      P_WALK:      return WK;
      P_SG, P_SGX: return SG;
      default:     return SY;
    endcase
  endfunction

  function automatic int phase_len(input phase_t p);
    int v;
    case (p)
      P_MY, P_SY:    v = m_yel;
      P_WALK, P_SGX: v = m_ext;
      default:       v = m_base;
    endcase
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_ph = P_G1; m_seen = 0; m_need = 0; m_first = 1; m_walk = 0;
    m_base = 6; m_ext = 3; m_yel = 2;
  endtask

  task automatic model_step();
    phase_t nxt;
    bit     done;
    if (Reprogram) begin
      case (Time_Parameter_Selector)
        2'd0: m_base = int'(Time_Value);
        2'd1: m_ext  = int'(Time_Value);
        2'd2: m_yel  = int'(Time_Value);
        default: ;
      endcase
      if (Walk_Request) m_walk = 1;
      m_ph = P_G1; m_first = 1; m_seen = 0;
      return;
    end
    if (m_first) m_need = phase_len(m_ph);
    done = !m_first && (m_seen >= m_need);
    nxt  = m_ph;
    if (done) begin
      case (m_ph)
        P_G1:    nxt = Sensor ? P_MY : P_G2;
        P_G2:    nxt = P_MY;
        P_MY:    nxt = m_walk ? P_WALK : P_SG;
        P_WALK:  nxt = P_SG;
        P_SG:    nxt = Sensor ? P_SGX : P_SY;
        P_SGX:   nxt = P_SY;
        default: nxt = P_G1;
      endcase
    end
    if (nxt == P_WALK) m_walk = 0;
    if (Walk_Request)  m_walk = 1;
    if (nxt != m_ph) begin
      m_ph = nxt; m_first = 1; m_seen = 0;
    end else begin
      m_seen += int'(tick); m_first = 0;
    end
  endtask

  // One clock with the given inputs; entered and left at a falling edge
  task automatic step(input logic rp, input logic [1:0] sel, input logic [3:0] val,
                      input logic sn, input logic wk, input logic tk);
    Reprogram = rp; Time_Parameter_Selector = sel; Time_Value = val;
    Sensor = sn; Walk_Request = wk; tick = tk;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [6:0] want);
    n_cmp++;
    if (LEDs !== want) begin
      n_bad++;
      $display("FAIL %s: LEDs got %b want %b", name, LEDs, want);
    end
  endtask

  typedef struct {
    logic       rp;
    logic [1:0] sel;
    logic [3:0] val;
    logic       sn;
    logic       wk;
    logic       tk;
    int         run;
    logic [6:0] leds;
  } vec_t;

  vec_t tbl[$];

  task automatic run_vectors(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].run; k++)
        step(tbl[i].rp, tbl[i].sel, tbl[i].val, tbl[i].sn, tbl[i].wk, tbl[i].tk);
      check($sformatf("%s_vec%0d", tag, i), tbl[i].leds);
    end
    tbl.delete();
  endtask

  initial begin
    Reset_n = 1'b0; tick = 1'b1; Sensor = 1'b0; Walk_Request = 1'b0;
    Reprogram = 1'b0; Time_Parameter_Selector = 2'd0; Time_Value = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_leds", MG);
    Reset_n = 1'b1;

    // Full cycle, no sensor, no walk: G1 7, G2 7, Y 3, SIDE_G 7, SIDE_Y 3
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1, 13, MG});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1,  1, MY});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1,  2, MY});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1,  1, SG});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1,  6, SG});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1,  1, SY});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1,  2, SY});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1,  1, MG});
    // Sensor held: G2 skipped, SIDE_GX extends side green to 11 clk
    tbl.push_back('{0, 2'd0, 4'd0, 1, 0, 1,  6, MG});
    tbl.push_back('{0, 2'd0, 4'd0, 1, 0, 1,  1, MY});
    tbl.push_back('{0, 2'd0, 4'd0, 1, 0, 1,  2, MY});
    tbl.push_back('{0, 2'd0, 4'd0, 1, 0, 1,  1, SG});
    tbl.push_back('{0, 2'd0, 4'd0, 1, 0, 1, 10, SG});
    tbl.push_back('{0, 2'd0, 4'd0, 1, 0, 1,  1, SY});
    tbl.push_back('{0, 2'd0, 4'd0, 1, 0, 1,  2, SY});
    tbl.push_back('{0, 2'd0, 4'd0, 1, 0, 1,  1, MG});
    run_vectors("basic");

    // Walk pulse in G1, second pulse inside WALK, third held across WALK entry
    tbl.push_back('{0, 2'd0, 4'd0, 0, 1, 1,  1, MG});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1, 15, MY});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1,  1, WK});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 1, 1,  1, WK});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1,  2, WK});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1,  1, SG});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1, 26, MY});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 1, 1,  1, WK});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1,  4, SG});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1, 26, MY});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1,  1, WK});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1,  4, SG});
    run_vectors("walk");

    // Yellow reprogrammed to 5, then sel=11 must leave every parameter alone
    tbl.push_back('{1, 2'd2, 4'd5, 0, 0, 1,  2, MG});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1, 14, MY});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1,  5, MY});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1,  1, SG});
    tbl.push_back('{1, 2'd3, 4'd1, 0, 0, 1,  2, MG});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1, 13, MG});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1,  1, MY});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1,  5, MY});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1,  1, SG});
    // Base of zero clamps to one tick; tick low stalls the yellow phase
    tbl.push_back('{1, 2'd0, 4'd0, 0, 0, 1,  1, MG});
    tbl.push_back('{0, 2'd0, 4'd0, 1, 0, 1,  1, MG});
    tbl.push_back('{0, 2'd0, 4'd0, 1, 0, 1,  1, MY});
    tbl.push_back('{0, 2'd0, 4'd0, 1, 0, 0, 20, MY});
    tbl.push_back('{0, 2'd0, 4'd0, 1, 0, 1,  5, MY});
    tbl.push_back('{0, 2'd0, 4'd0, 1, 0, 1,  1, SG});
    run_vectors("prog");

    // Randomised traffic against the phase model
    for (int c = 0; c < 3000; c++) begin
      logic rp;
      rp = ($urandom_range(0, 99) < 3);
      step(rp, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 8),
           ($urandom_range(0, 99) < 75));
      check($sformatf("rand_c%0d", c), phase_led(m_ph));
    end

    // Reset in the middle of a non-main-green phase must act without a clock edge
    for (int c = 0; c < 60 && LEDs == MG; c++) step(0, 2'd0, 4'd0, 0, 0, 1);
    #2 Reset_n = 1'b0;
    #1 check("async_reset", MG);
    model_reset();
    @(negedge clk);
    Reset_n = 1'b1;
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1, 13, MG});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1,  1, MY});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1,  2, MY});
    tbl.push_back('{0, 2'd0, 4'd0, 0, 0, 1,  1, SG});
    run_vectors("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
